// File: rtl/resp_route_if.sv
// Handshake bundle between the arbiter/memory side and the read/write
// response consumers of resp_route. The slave modport is the router's view.
interface resp_route_if #(
  parameter int R_WIDTH = 32,
  parameter int W_WIDTH = 64
);
  logic               tag_valid;
  logic               tag_is_write;
  logic               tag_ready;
  logic               in_valid;
  logic [W_WIDTH-1:0] in_data;
  logic               in_ready;
  logic               r_valid;
  logic [R_WIDTH-1:0] r_data;
  logic               r_ready;
  logic               b_valid;
  logic [1:0]         b_resp;
  logic               b_ready;
  logic               orphan_err;

  modport master (
    output tag_valid, tag_is_write, in_valid, in_data, r_ready, b_ready,
    input  tag_ready, in_ready, r_valid, r_data, b_valid, b_resp, orphan_err
  );

  modport slave (
    input  tag_valid, tag_is_write, in_valid, in_data, r_ready, b_ready,
    output tag_ready, in_ready, r_valid, r_data, b_valid, b_resp, orphan_err
  );
endinterface

// File: rtl/resp_route.sv
// Response router: remembers the grant type (read/write) of each
// outstanding request in a small tag FIFO and steers the memory-side
// responses, in grant order, to a read-data channel or a write-status
// channel. Each output channel is a single registered slot.
module resp_route #(
  parameter int R_WIDTH = 32,
  parameter int W_WIDTH = 64,
  parameter int DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  resp_route_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Tag storage: 1 = write grant, 0 = read grant
  logic [DEPTH-1:0]   tag_mem;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic               full;
  logic               empty;
  logic               head_is_write;
  logic               push;
  logic               xfer;
  logic               rd_xfer;
  logic               wr_xfer;
  logic               in_ready_c;

  logic               r_valid_q;
  logic [R_WIDTH-1:0] r_data_q;
  logic               b_valid_q;
  logic [1:0]         b_resp_q;
  logic               orphan_q;

  logic [W_WIDTH-1:0] in_word;
  logic               unused_in_word;

  assign in_word        = bus.in_data;
  assign unused_in_word = ^in_word;

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign head_is_write = tag_mem[rd_ptr];

  // Only the channel the head tag targets matters; the other channel may
  // be stalled without blocking this response.
  assign in_ready_c = !empty && (head_is_write ? (!b_valid_q || bus.b_ready)
                                               : (!r_valid_q || bus.r_ready));

  assign push    = bus.tag_valid && !full;
  assign xfer    = bus.in_valid && in_ready_c;
  assign rd_xfer = xfer && !head_is_write;
  assign wr_xfer = xfer && head_is_write;

  assign bus.tag_ready  = !full;
  assign bus.in_ready   = in_ready_c;
  assign bus.r_valid    = r_valid_q;
  assign bus.r_data     = r_data_q;
  assign bus.b_valid    = b_valid_q;
  assign bus.b_resp     = b_resp_q;
  assign bus.orphan_err = orphan_q;

  // Tag payload storage; contents are only meaningful below count
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= bus.tag_is_write;
  end

  // FIFO pointers and occupancy; a response transfer pops the head tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (xfer) rd_ptr <= rd_ptr + 1'b1;
      case ({push, xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read channel slot: load on read transfer, clear when consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else if (rd_xfer) begin
      r_valid_q <= 1'b1;
      r_data_q  <= in_word[R_WIDTH-1:0];
    end else if (bus.r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  // Write-status slot: load on write transfer, clear when consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
    end else if (wr_xfer) begin
      b_valid_q <= 1'b1;
      b_resp_q  <= in_word[1:0];
    end else if (bus.b_ready) begin
      b_valid_q <= 1'b0;
    end
  end

  // Sticky flag for a response that shows up with nothing outstanding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) orphan_q <= 1'b0;
    else if (bus.in_valid && empty) orphan_q <= 1'b1;
  end
endmodule

// File: tb/tb_resp_route.sv
// Directed bench for resp_route: ordering, full FIFO, backpressure,
// channel independence, orphan flag, asynchronous reset and streaming.
module tb_resp_route;
  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   accepted;

  resp_route_if #(.R_WIDTH(32), .W_WIDTH(64)) bus ();

  resp_route #(.R_WIDTH(32), .W_WIDTH(64), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    accepted = 0;
    rst = 1'b0;
    bus.tag_valid = 1'b0;
    bus.tag_is_write = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.r_ready = 1'b1;
    bus.b_ready = 1'b1;
    #2;
    chk("rst_tag_ready", bus.tag_ready, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    chk("rst_b_resp", bus.b_resp, 0);
    chk("rst_orphan", bus.orphan_err, 0);
    tick();
    rst = 1'b1;
    tick();

    // Order: tags R, W, R
    bus.tag_valid = 1'b1; bus.tag_is_write = 1'b0; tick();
    bus.tag_is_write = 1'b1; tick();
    bus.tag_is_write = 1'b0; tick();
    bus.tag_valid = 1'b0;
    #1;
    chk("ord_count3", dut.count, 3);
    bus.in_valid = 1'b1; bus.in_data = 64'h1234_5678_0000_AAAA;
    #1;
    chk("ord_in_ready1", bus.in_ready, 1);
    tick();
    chk("ord_r_valid1", bus.r_valid, 1);
    chk("ord_r_data1", bus.r_data, 32'h0000_AAAA);
    chk("ord_b_valid1", bus.b_valid, 0);
    bus.in_data = 64'hFFFF_0000_0000_0001;
    #1;
    chk("ord_in_ready2", bus.in_ready, 1);
    tick();
    chk("ord_b_valid2", bus.b_valid, 1);
    chk("ord_b_resp2", bus.b_resp, 2'b01);
    chk("ord_r_valid2", bus.r_valid, 0);
    bus.in_data = 64'h0000_0000_0000_BBBB;
    tick();
    chk("ord_r_valid3", bus.r_valid, 1);
    chk("ord_r_data3", bus.r_data, 32'h0000_BBBB);
    chk("ord_b_valid3", bus.b_valid, 0);
    bus.in_valid = 1'b0;
    tick();
    chk("ord_r_drain", bus.r_valid, 0);
    chk("ord_count0", dut.count, 0);

    // Full: four read tags, a fifth is refused
    bus.tag_valid = 1'b1; bus.tag_is_write = 1'b0;
    repeat (4) tick();
    chk("full_tag_ready0", bus.tag_ready, 0);
    bus.tag_is_write = 1'b1;
    tick();
    chk("full_count4", dut.count, 4);
    chk("full_still_full", bus.tag_ready, 0);
    bus.tag_valid = 1'b0;
    bus.r_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_1111_2222;
    #1;
    chk("full_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("full_tag_ready1", bus.tag_ready, 1);
    chk("full_count3", dut.count, 3);
    chk("full_r_data", bus.r_data, 32'h1111_2222);

    // Backpressure: head read, read slot held
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_3333_4444;
    #1;
    chk("bp_in_ready0", bus.in_ready, 0);
    tick();
    chk("bp_r_valid_hold", bus.r_valid, 1);
    chk("bp_r_data_hold1", bus.r_data, 32'h1111_2222);
    tick();
    chk("bp_r_data_hold2", bus.r_data, 32'h1111_2222);
    bus.r_ready = 1'b1;
    #1;
    chk("bp_in_ready1", bus.in_ready, 1);
    tick();
    chk("bp_r_data_new", bus.r_data, 32'h3333_4444);
    chk("bp_r_valid_kept", bus.r_valid, 1);
    bus.in_data = 64'h0000_0000_5555_6666; tick();
    bus.in_data = 64'h0000_0000_7777_8888; tick();
    chk("bp_r_data_last", bus.r_data, 32'h7777_8888);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_count0", dut.count, 0);
    chk("bp_r_valid0", bus.r_valid, 0);

    // Channel independence: held read does not stall a head write
    bus.r_ready = 1'b0; bus.b_ready = 1'b0;
    bus.tag_valid = 1'b1; bus.tag_is_write = 1'b0; tick();
    bus.tag_is_write = 1'b1; tick();
    bus.tag_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0000_9999;
    tick();
    chk("ind_r_data", bus.r_data, 32'h0000_9999);
    bus.in_data = 64'h0000_0000_0000_0002;
    #1;
    chk("ind_in_ready_w", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("ind_b_valid", bus.b_valid, 1);
    chk("ind_b_resp", bus.b_resp, 2'b10);
    chk("ind_r_hold", bus.r_data, 32'h0000_9999);
    chk("ind_r_valid_hold", bus.r_valid, 1);
    bus.r_ready = 1'b1; bus.b_ready = 1'b1;
    tick();
    chk("ind_r_clear", bus.r_valid, 0);
    chk("ind_b_clear", bus.b_valid, 0);

    // Orphan response with nothing outstanding
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0000_CCCC;
    #1;
    chk("orph_in_ready", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("orph_flag", bus.orphan_err, 1);
    chk("orph_no_r", bus.r_valid, 0);
    repeat (10) tick();
    chk("orph_sticky", bus.orphan_err, 1);

    // No bypass: tag pushed while a response waits on an empty FIFO
    bus.tag_valid = 1'b1; bus.tag_is_write = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0000_0003;
    #1;
    chk("byp_in_ready0", bus.in_ready, 0);
    tick();
    bus.tag_valid = 1'b0;
    #1;
    chk("byp_in_ready1", bus.in_ready, 1);
    bus.b_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("byp_b_resp", bus.b_resp, 2'b11);

    // Mid-operation reset with three tags and a held write status
    bus.tag_valid = 1'b1; bus.tag_is_write = 1'b0; tick();
    bus.tag_is_write = 1'b1; tick();
    bus.tag_is_write = 1'b0; tick();
    bus.tag_valid = 1'b0;
    #1;
    chk("mr_pre_count", dut.count, 3);
    chk("mr_pre_b_valid", bus.b_valid, 1);
    rst = 1'b0;
    #1;
    chk("mr_tag_ready", bus.tag_ready, 1);
    chk("mr_in_ready", bus.in_ready, 0);
    chk("mr_b_valid", bus.b_valid, 0);
    chk("mr_b_resp", bus.b_resp, 0);
    chk("mr_r_valid", bus.r_valid, 0);
    chk("mr_r_data", bus.r_data, 0);
    chk("mr_orphan", bus.orphan_err, 0);
    chk("mr_count", dut.count, 0);
    tick();
    rst = 1'b1;
    bus.b_ready = 1'b1;
    tick();
    chk("mr_post_tag_ready", bus.tag_ready, 1);
    chk("mr_post_count", dut.count, 0);
    chk("mr_post_b_valid", bus.b_valid, 0);
    chk("mr_post_r_valid", bus.r_valid, 0);

    // Streaming: alternating tags, one response per cycle
    for (int i = 0; i <= 8; i++) begin
      bus.tag_valid = (i < 8);
      bus.tag_is_write = i[0];
      bus.in_valid = (i > 0);
      bus.in_data = 64'h0000_0000_0000_00F0 + 64'(i - 1);
      #1;
      if (i > 0) begin
        chk("strm_in_ready", bus.in_ready, 1);
        if (bus.in_ready && bus.in_valid) accepted++;
      end
      tick();
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk("strm_r_valid", bus.r_valid, 1);
          chk("strm_r_data", bus.r_data, 32'h0000_00F0 + 32'(i - 1));
        end else begin
          chk("strm_b_valid", bus.b_valid, 1);
          chk("strm_b_resp", bus.b_resp, ((i - 1) % 4 == 1) ? 2'b01 : 2'b11);
        end
      end
    end
    bus.tag_valid = 1'b0;
    bus.in_valid = 1'b0;
    chk("strm_accepted", accepted, 8);
    tick();
    chk("strm_count0", dut.count, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/resp_route.md
RESP_ROUTE -- requirements
Module: resp_route

Interface
REQ-001 Parameter: R_WIDTH, default 32, read-data width.
REQ-002 Parameter: W_WIDTH, default 64, width of the unified response bus.
REQ-003 Parameter: DEPTH, default 4, outstanding-tag FIFO depth; power of two, at least 2.
REQ-004 Port: clk  input  1  sole clock; all logic is rising-edge.
REQ-005 Port: rst  input  1  reset; asynchronous assert, active-low.
REQ-006 Port: tag_valid  input  1  arbiter has granted a request.
REQ-007 Port: tag_is_write  input  1  grant type of that request: 0=read, 1=write.
REQ-008 Port: tag_ready  output  1  tag FIFO can accept a tag.
REQ-009 Port: in_valid  input  1  memory-side response valid.
REQ-010 Port: in_data  input  W_WIDTH  memory-side response payload.
REQ-011 Port: in_ready  output  1  response accepted this cycle.
REQ-012 Port: r_valid  output  1  read response valid.
REQ-013 Port: r_data  output  R_WIDTH  read data.
REQ-014 Port: r_ready  input  1  read consumer ready.
REQ-015 Port: b_valid  output  1  write response valid.
REQ-016 Port: b_resp  output  2  write status.
REQ-017 Port: b_ready  input  1  write consumer ready.
REQ-018 Port: orphan_err  output  1  sticky flag: a response arrived with no tag outstanding.

Function
REQ-019 Tag FIFO: a tag is pushed when tag_valid && tag_ready; tag_ready = !full. A pop in the same cycle does not raise tag_ready when the FIFO is full.
REQ-020 The FIFO occupancy count SHALL be $clog2(DEPTH)+1 bits wide, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-021 Head tag: tag_is_write of the oldest entry; responses return in grant order.
REQ-022 in_ready SHALL be !empty && (head==0 ? (!r_valid || r_ready) : (!b_valid || b_ready)).
REQ-023 There is no tag bypass: with the FIFO empty, in_ready=0 even if a tag is pushed in the same cycle.
REQ-024 Transfer: when in_valid && in_ready, the head tag is popped in that cycle.
REQ-025 Read transfer: on the next edge r_data <= in_data[R_WIDTH-1:0] and r_valid <= 1.
REQ-026 Write transfer: on the next edge b_resp <= in_data[1:0] and b_valid <= 1.
REQ-027 Latency: one cycle from accepted response to the output valid.
REQ-028 r_valid clears on r_ready when no new read transfer occurs in the same cycle; b_valid/b_ready behave identically.
REQ-029 If an output is consumed and a new transfer to the same channel occurs in the same cycle, valid stays 1 and the data updates.
REQ-030 While a channel holds valid and its ready=0, its data and status SHALL hold stable.
REQ-031 A held read output SHALL NOT block a head write response, and a held write output SHALL NOT block a head read response.
REQ-032 Simultaneous push and pop on a non-full FIFO leaves the occupancy count unchanged.
REQ-033 in_valid with the FIFO empty sets orphan_err to 1; orphan_err stays 1 until reset and the response is not accepted.
REQ-034 Throughput: one response per cycle sustained when the consumer is ready.

Reset
REQ-035 When rst=0 the block resets immediately, regardless of clk: FIFO empty, pointers 0, tag_ready=1, in_ready=0, r_valid=0, r_data=0, b_valid=0, b_resp=0, orphan_err=0.
REQ-036 Reset mid-operation discards all outstanding tags and held outputs; no output pulses after release.
REQ-037 Operation resumes on the first rising clk edge after rst returns to 1.

Verification
REQ-038 Order test: push tags R,W,R; present responses 0x..AAAA, 0x..0001, 0x..BBBB -> the bench sees r_data=0xAAAA, then b_resp=01, then r_data=0xBBBB, each one cycle after acceptance.
REQ-039 Full test: push 4 tags with no responses -> tag_ready=0 after the 4th push; a 5th tag_valid is ignored; one read response -> tag_ready=1 on the next cycle.
REQ-040 Backpressure test: head=R with r_valid held and r_ready=0 -> in_ready=0 and r_data stable; r_ready=1 -> in_ready=1 in the same cycle and the data updates on the next edge.
REQ-041 Orphan test: in_valid=1 with the FIFO empty -> in_ready=0 and orphan_err=1, still 1 after 10 cycles.
REQ-042 Mid-reset test: 3 tags outstanding and b_valid=1, assert rst between clock edges -> all outputs at reset values immediately; after release tag_ready=1 and the count is 0.
REQ-043 Streaming test: 8 alternating tags with r_ready=b_ready=1 -> 8 responses accepted in 8 consecutive cycles with no bubbles.
